crc8_frame_checker: RTL and testbench
=====================================

CRC8_FRAME_CHECKER -- requirements
Module: crc8_frame_checker

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 64, giving the number of payload bits per frame (legal range 1..65535).
REQ-002 SHALL have ports clk_i (input, 1): sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_i (input, 1): reset, asynchronous, active-low.
REQ-004 SHALL have ports start_i (input, 1): one-cycle frame start request.
REQ-005 SHALL have ports abort_i (input, 1): abandon the current frame.
REQ-006 SHALL have ports valid_i (input, 1): data_i carries a bit this cycle.
REQ-007 SHALL have ports data_i (input, 1): serial bit, MSB-first.
REQ-008 SHALL have ports busy_o (output, 1): frame in progress.
REQ-009 SHALL have ports done_o (output, 1): one-cycle frame-complete pulse.
REQ-010 SHALL have ports crc_ok_o (output, 1): last frame CRC matched.
REQ-011 SHALL have ports crc_err_o (output, 1): last frame CRC mismatched.
REQ-012 SHALL have ports crc_calc_o (output, 8): computed CRC.
REQ-013 SHALL have ports crc_rx_o (output, 8): received CRC byte.

Function
REQ-014 SHALL implement FSM states IDLE, PAYLOAD, CRCRX and DONE.
REQ-015 SHALL leave IDLE for PAYLOAD when start_i=1; start_i in any other state SHALL be ignored.
REQ-016 Entering PAYLOAD SHALL clear the CRC register to 0x00, clear the bit counter, and clear crc_ok_o/crc_err_o.
REQ-017 In PAYLOAD, each cycle with valid_i=1 SHALL consume one bit, update the CRC and increment the counter; valid_i=0 SHALL hold all state.
REQ-018 CRC update SHALL be, with c=current and d=data_i:
- n0=d^c7, n1=c0^c7, n2=c1, n3=c2^c7
- n4=c3, n5=c4^c7, n6=c5^c7, n7=c6^c7
REQ-019 After the FRAME_BITS-th consumed payload bit, the FSM SHALL go to CRCRX with the counter cleared; the CRC register SHALL then be frozen.
REQ-020 In CRCRX, each valid bit SHALL shift into crc_rx_o from the LSB end (crc_rx_o <= {crc_rx_o[6:0], data_i}), so the first bit received becomes the MSB.
REQ-021 After the 8th CRC bit the FSM SHALL go to DONE.
REQ-022 In DONE, the block SHALL compare crc_rx_o with crc_calc_o, then:
- set exactly one of crc_ok_o/crc_err_o;
- pulse done_o for exactly one cycle;
- return to IDLE on the next edge.
REQ-023 Latency SHALL be: done_o high in the cycle immediately after the edge that consumed the 8th CRC bit.
REQ-024 crc_ok_o, crc_err_o, crc_calc_o and crc_rx_o SHALL hold their values in IDLE until the next accepted start_i.
REQ-025 busy_o SHALL be 1 in PAYLOAD, CRCRX and DONE, and 0 in IDLE.
REQ-026 abort_i=1 in any non-IDLE state SHALL return the FSM to IDLE next edge:
- done_o not pulsed;
- crc_ok_o=crc_err_o=0;
- abort_i has priority over valid_i.
REQ-027 start_i and abort_i asserted together in IDLE SHALL be treated as abort (remain IDLE).
REQ-028 The bit counter SHALL be $clog2(FRAME_BITS+1) bits wide and SHALL never wrap within a frame.

Reset
REQ-029 rst_i=0 SHALL asynchronously force state IDLE, counter 0, and crc_calc_o, crc_rx_o, busy_o, done_o, crc_ok_o, crc_err_o all 0.
REQ-030 Reset asserted mid-frame SHALL discard the frame with no done_o pulse; after release the block SHALL accept start_i on the first clock edge.

Structure
REQ-031 FSM state encodings and the CRC polynomial constant 8'hEB SHALL live in a shared package; FRAME_BITS SHALL stay a module parameter.
REQ-032 The REQ-018 update SHALL be a sub-module crc8_lfsr_step with ports clk_i, rst_i, clr_i, en_i, data_i and crc_o[7:0].

Verification (FRAME_BITS=8)
REQ-033 Send payload 0x00, then CRC 0x00 -> done_o one-cycle pulse, crc_ok_o=1, crc_calc_o=0x00.
REQ-034 Send payload 0x80, then CRC 0x80 -> crc_ok_o=1; payload 0xFF, then CRC 0xFF -> crc_ok_o=1.
REQ-035 Send payload 0x01, then CRC 0x02 -> crc_err_o=1, crc_calc_o=0x01, crc_rx_o=0x02.
REQ-036 Send payload 0xFF with valid_i toggling 1/0 every cycle -> same result as a contiguous frame; start_i pulsed mid-frame is ignored.
REQ-037 Assert abort_i after 5 payload bits -> busy_o=0 next cycle, no done_o; then a new frame with payload 0x80 / CRC 0x80 -> crc_ok_o=1.
REQ-038 Drive rst_i low asynchronously mid-CRCRX -> all outputs 0 immediately, no done_o pulse.

Source files
------------

// File: rtl/crc8_frame_checker_pkg.sv
// Shared definitions for the serial CRC-8 frame checker: FSM encoding,
// generator polynomial and the single-bit CRC step function.
package crc8_frame_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CRCRX   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'hEB;

    // Shift in one bit; the outgoing MSB selects whether the polynomial is folded in.
    function automatic logic [7:0] crc8_next(input logic [7:0] c, input logic d);
        return {c[6:0], d} ^ (c[7] ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_lfsr_step.sv
// CRC-8 register advanced by one serial bit per enabled cycle; clear wins over enable.
module crc8_lfsr_step
    import crc8_frame_checker_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       data_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = 8'h00;
        end else if (en_i) begin
            crc_d = crc8_next(crc_q, data_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/crc8_frame_checker.sv
// Serial frame checker: FRAME_BITS payload bits MSB-first, then an 8-bit CRC,
// compared against the locally computed CRC-8 (poly 0xEB, init 0x00).
module crc8_frame_checker
    import crc8_frame_checker_pkg::*;
#(
    parameter int FRAME_BITS = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       valid_i,
    input  logic       data_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       crc_ok_o,
    output logic       crc_err_o,
    output logic [7:0] crc_calc_o,
    output logic [7:0] crc_rx_o
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       rx_cnt_q, rx_cnt_d;
    logic [7:0]       rx_q, rx_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic             crc_clr;
    logic             crc_en;
    logic [7:0]       rx_next;
    logic [7:0]       crc_calc;

    crc8_lfsr_step u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (crc_clr),
        .en_i   (crc_en),
        .data_i (data_i),
        .crc_o  (crc_calc)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rx_cnt_d = rx_cnt_q;
        rx_d     = rx_q;
        ok_d     = ok_q;
        err_d    = err_q;
        crc_clr  = 1'b0;
        crc_en   = 1'b0;
        rx_next  = {rx_q[6:0], data_i};

        // Abort outranks everything once a frame is underway.
        if (state_q != ST_IDLE && abort_i) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            rx_cnt_d = 3'd0;
            ok_d     = 1'b0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !abort_i) begin
                        state_d = ST_PAYLOAD;
                        cnt_d   = '0;
                        ok_d    = 1'b0;
                        err_d   = 1'b0;
                        crc_clr = 1'b1;
                    end
                end
                ST_PAYLOAD: begin
                    if (valid_i) begin
                        crc_en = 1'b1;
                        if (cnt_q == LAST_BIT) begin
                            state_d  = ST_CRCRX;
                            cnt_d    = '0;
                            rx_cnt_d = 3'd0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_CRCRX: begin
                    if (valid_i) begin
                        rx_d = rx_next;
                        // Verdict is registered with the last bit so it is valid alongside done_o.
                        if (rx_cnt_q == 3'd7) begin
                            state_d  = ST_DONE;
                            rx_cnt_d = 3'd0;
                            ok_d     = (rx_next == crc_calc);
                            err_d    = (rx_next != crc_calc);
                        end else begin
                            rx_cnt_d = rx_cnt_q + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rx_cnt_q <= 3'd0;
            rx_q     <= 8'h00;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rx_cnt_q <= rx_cnt_d;
            rx_q     <= rx_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
        end
    end

    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign crc_ok_o   = ok_q;
    assign crc_err_o  = err_q;
    assign crc_calc_o = crc_calc;
    assign crc_rx_o   = rx_q;

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Directed bench: 8-bit frame checker for the main scenarios, plus a 16-bit
// instance whose longer payload exercises the polynomial feedback path.
module tb_crc8_frame_checker;

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    logic start_i = 1'b0;
    logic valid_i = 1'b0;
    logic data_i = 1'b0;
    logic abort8 = 1'b0;
    logic abort16 = 1'b1;

    logic       busy8, done8, ok8, err8;
    logic [7:0] calc8, rx8;
    logic       busy16, done16, ok16, err16;
    logic [7:0] calc16, rx16;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    crc8_frame_checker #(.FRAME_BITS(8)) dut8 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort8),
        .valid_i(valid_i), .data_i(data_i), .busy_o(busy8), .done_o(done8),
        .crc_ok_o(ok8), .crc_err_o(err8), .crc_calc_o(calc8), .crc_rx_o(rx8)
    );

    crc8_frame_checker #(.FRAME_BITS(16)) dut16 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort16),
        .valid_i(valid_i), .data_i(data_i), .busy_o(busy16), .done_o(done16),
        .crc_ok_o(ok16), .crc_err_o(err16), .crc_calc_o(calc16), .crc_rx_o(rx16)
    );

    task automatic do_start();
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
    endtask

    // Sends n bits of v MSB-first; with gap, an idle cycle precedes every bit.
    // Returns at the negedge right after the edge that consumed the last bit.
    task automatic send_bits(input logic [15:0] v, input int n, input bit gap);
        for (int i = n - 1; i >= 0; i--) begin
            if (gap) begin
                valid_i = 1'b0;
                @(negedge clk);
            end
            valid_i = 1'b1;
            data_i  = v[i];
            @(negedge clk);
        end
        valid_i = 1'b0;
        data_i  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy8); end
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done8); end
        total++; if (ok8 !== 1'b0) begin bad++; $display("FAIL reset_ok: got %b want 0", ok8); end
        total++; if (err8 !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err8); end
        total++; if (calc8 !== 8'h00) begin bad++; $display("FAIL reset_calc: got %h want 00", calc8); end
        total++; if (rx8 !== 8'h00) begin bad++; $display("FAIL reset_rx: got %h want 00", rx8); end
        @(negedge clk); rst_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_frame();
        do_start();
        total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL zero_busy_payload: got %b want 1", busy8); end
        send_bits(16'h0000, 8, 1'b0);
        send_bits(16'h0000, 8, 1'b0);
        total++; if (done8 !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", done8); end
        total++; if (ok8 !== 1'b1) begin bad++; $display("FAIL zero_ok: got %b want 1", ok8); end
        total++; if (err8 !== 1'b0) begin bad++; $display("FAIL zero_err: got %b want 0", err8); end
        total++; if (calc8 !== 8'h00) begin bad++; $display("FAIL zero_calc: got %h want 00", calc8); end
        @(negedge clk);
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL zero_done_pulse: got %b want 0", done8); end
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL zero_idle_busy: got %b want 0", busy8); end
        total++; if (ok8 !== 1'b1) begin bad++; $display("FAIL zero_ok_hold: got %b want 1", ok8); end
    endtask

    task automatic test_match();
        do_start();
        send_bits(16'h0080, 8, 1'b0);
        send_bits(16'h0080, 8, 1'b0);
        total++; if (ok8 !== 1'b1) begin bad++; $display("FAIL m80_ok: got %b want 1", ok8); end
        total++; if (calc8 !== 8'h80) begin bad++; $display("FAIL m80_calc: got %h want 80", calc8); end
        total++; if (rx8 !== 8'h80) begin bad++; $display("FAIL m80_rx: got %h want 80", rx8); end
        @(negedge clk);
        do_start();
        send_bits(16'h00FF, 8, 1'b0);
        send_bits(16'h00FF, 8, 1'b0);
        total++; if (done8 !== 1'b1) begin bad++; $display("FAIL mff_done: got %b want 1", done8); end
        total++; if (ok8 !== 1'b1) begin bad++; $display("FAIL mff_ok: got %b want 1", ok8); end
        total++; if (calc8 !== 8'hFF) begin bad++; $display("FAIL mff_calc: got %h want ff", calc8); end
        @(negedge clk);
    endtask

    task automatic test_mismatch();
        do_start();
        total++; if (ok8 !== 1'b0) begin bad++; $display("FAIL mis_ok_cleared: got %b want 0", ok8); end
        send_bits(16'h0001, 8, 1'b0);
        send_bits(16'h0002, 8, 1'b0);
        total++; if (done8 !== 1'b1) begin bad++; $display("FAIL mis_done: got %b want 1", done8); end
        total++; if (err8 !== 1'b1) begin bad++; $display("FAIL mis_err: got %b want 1", err8); end
        total++; if (ok8 !== 1'b0) begin bad++; $display("FAIL mis_ok: got %b want 0", ok8); end
        total++; if (calc8 !== 8'h01) begin bad++; $display("FAIL mis_calc: got %h want 01", calc8); end
        total++; if (rx8 !== 8'h02) begin bad++; $display("FAIL mis_rx: got %h want 02", rx8); end
        @(negedge clk);
        total++; if (err8 !== 1'b1) begin bad++; $display("FAIL mis_err_hold: got %b want 1", err8); end
    endtask

    task automatic test_gapped_valid();
        do_start();
        send_bits(16'h000F, 4, 1'b1);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL gap_busy_mid: got %b want 1", busy8); end
        send_bits(16'h000F, 4, 1'b1);
        send_bits(16'h00FF, 8, 1'b1);
        total++; if (done8 !== 1'b1) begin bad++; $display("FAIL gap_done: got %b want 1", done8); end
        total++; if (ok8 !== 1'b1) begin bad++; $display("FAIL gap_ok: got %b want 1", ok8); end
        total++; if (calc8 !== 8'hFF) begin bad++; $display("FAIL gap_calc: got %h want ff", calc8); end
        total++; if (rx8 !== 8'hFF) begin bad++; $display("FAIL gap_rx: got %h want ff", rx8); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        do_start();
        send_bits(16'h00FF, 5, 1'b0);
        abort8  = 1'b1;
        valid_i = 1'b1;
        data_i  = 1'b1;
        @(negedge clk);
        abort8  = 1'b0;
        valid_i = 1'b0;
        data_i  = 1'b0;
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy8); end
        total++; if (ok8 !== 1'b0) begin bad++; $display("FAIL abort_ok: got %b want 0", ok8); end
        total++; if (err8 !== 1'b0) begin bad++; $display("FAIL abort_err: got %b want 0", err8); end
        for (int i = 0; i < 12; i++) begin
            total++; if (done8 !== 1'b0) begin bad++; $display("FAIL abort_no_done[%0d]: got %b want 0", i, done8); end
            @(negedge clk);
        end
        start_i = 1'b1;
        abort8  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        abort8  = 1'b0;
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL start_abort_idle: got %b want 0", busy8); end
        do_start();
        send_bits(16'h0080, 8, 1'b0);
        send_bits(16'h0080, 8, 1'b0);
        total++; if (done8 !== 1'b1) begin bad++; $display("FAIL post_abort_done: got %b want 1", done8); end
        total++; if (ok8 !== 1'b1) begin bad++; $display("FAIL post_abort_ok: got %b want 1", ok8); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        do_start();
        send_bits(16'h00FF, 8, 1'b0);
        send_bits(16'h0005, 3, 1'b0);
        total++; if (rx8 !== 8'h05) begin bad++; $display("FAIL rstmid_rx_before: got %h want 05", rx8); end
        #2 rst_i = 1'b0;
        #1;
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy8); end
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL rstmid_done: got %b want 0", done8); end
        total++; if (calc8 !== 8'h00) begin bad++; $display("FAIL rstmid_calc: got %h want 00", calc8); end
        total++; if (rx8 !== 8'h00) begin bad++; $display("FAIL rstmid_rx: got %h want 00", rx8); end
        total++; if ((ok8 | err8) !== 1'b0) begin bad++; $display("FAIL rstmid_flags: got %b%b want 00", ok8, err8); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (done8 !== 1'b0) begin bad++; $display("FAIL rstmid_no_done[%0d]: got %b want 0", i, done8); end
        end
        rst_i   = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL rstmid_first_start: got %b want 1", busy8); end
        abort8 = 1'b1;
        @(negedge clk);
        abort8 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_feedback16();
        abort8  = 1'b1;
        abort16 = 1'b0;
        do_start();
        send_bits(16'h8000, 16, 1'b0);
        send_bits(16'h0018, 8, 1'b0);
        total++; if (done16 !== 1'b1) begin bad++; $display("FAIL fb16_done: got %b want 1", done16); end
        total++; if (calc16 !== 8'h18) begin bad++; $display("FAIL fb16_calc: got %h want 18", calc16); end
        total++; if (ok16 !== 1'b1) begin bad++; $display("FAIL fb16_ok: got %b want 1", ok16); end
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL fb16_dut8_idle: got %b want 0", busy8); end
        @(negedge clk);
        abort8  = 1'b0;
        abort16 = 1'b1;
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_match();
        test_mismatch();
        test_gapped_valid();
        test_abort();
        test_reset_mid_frame();
        test_feedback16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
